// File: rtl/encode_lsps_pack.sv
// ----------------------------------------------------------------------------
// encode_lsps_pack
//
// Packs ten scalar LSP quantiser indexes into a 36-bit frame and streams the
// frame out MSB-first, one bit per cycle.
//
// Field layout (MSB first): indexes0..6 use 4 bits each, indexes7..8 use
// 3 bits each, and indexes9 uses 2 bits. index0 lands at bits_out[35].
//
// Optional build macro:
//   ENCODE_LSPS_PACK_GRAY_EN - when defined, each masked index is Gray coded
//                              (g = x ^ (x >> 1)) at LOAD. Timing and
//                              interface are the same in both builds.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   start_pack   in   frame start request, only honoured in IDLE
//   indexes0..9  in   quantiser indexes, captured at LOAD
//   bits_out     out  packed frame, filled MSB-first while shifting
//   bit_serial   out  current serial bit
//   bit_valid    out  qualifies bit_serial
//   nbit         out  number of bits emitted in the current frame (0..36)
//   done_pack    out  one-cycle frame-complete pulse
//
// State table:
//   state   | meaning
//   IDLE    | waiting for start_pack
//   LOAD    | capture coded indexes, clear frame, point at index0 MSB
//   SHIFT   | emit one bit per cycle, 36 cycles
//   DONE    | raise done_pack for one cycle
// ----------------------------------------------------------------------------
module encode_lsps_pack #(
    parameter int TOTAL_BITS = 36,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_pack,
    input  logic [IDX_W-1:0]      indexes0,
    input  logic [IDX_W-1:0]      indexes1,
    input  logic [IDX_W-1:0]      indexes2,
    input  logic [IDX_W-1:0]      indexes3,
    input  logic [IDX_W-1:0]      indexes4,
    input  logic [IDX_W-1:0]      indexes5,
    input  logic [IDX_W-1:0]      indexes6,
    input  logic [IDX_W-1:0]      indexes7,
    input  logic [IDX_W-1:0]      indexes8,
    input  logic [IDX_W-1:0]      indexes9,
    output logic [TOTAL_BITS-1:0] bits_out,
    output logic                  bit_serial,
    output logic                  bit_valid,
    output logic [5:0]            nbit,
    output logic                  done_pack
);

    localparam int N_IDX = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]      idx_in [N_IDX];
    logic [IDX_W-1:0]      code_q [N_IDX];
    logic [IDX_W-1:0]      code_d [N_IDX];
    logic [TOTAL_BITS-1:0] bits_out_q, bits_out_d;
    logic [5:0]            nbit_q, nbit_d;
    logic                  bit_serial_q, bit_serial_d;
    logic                  bit_valid_q, bit_valid_d;
    logic                  done_pack_q, done_pack_d;
    logic [3:0]            i_q, i_d;
    logic [1:0]            b_q, b_d;

    logic                  cur_bit;
    logic [5:0]            wr_idx;

    assign idx_in[0] = indexes0;
    assign idx_in[1] = indexes1;
    assign idx_in[2] = indexes2;
    assign idx_in[3] = indexes3;
    assign idx_in[4] = indexes4;
    assign idx_in[5] = indexes5;
    assign idx_in[6] = indexes6;
    assign idx_in[7] = indexes7;
    assign idx_in[8] = indexes8;
    assign idx_in[9] = indexes9;

    // Bit pointer of the MSB of field k (field width minus one).
    function automatic logic [1:0] msb_ptr(input logic [3:0] k);
        if (k < 4'd7) begin
            return 2'd3;
        end else if (k < 4'd9) begin
            return 2'd2;
        end else begin
            return 2'd1;
        end
    endfunction

    // Mask keeping only the bits that belong to field k.
    function automatic logic [IDX_W-1:0] field_mask(input int k);
        logic [IDX_W-1:0] m;
        int               w;
        w = (k < 7) ? 4 : ((k < 9) ? 3 : 2);
        for (int j = 0; j < IDX_W; j++) begin
            m[j] = (j < w);
        end
        return m;
    endfunction

    // Gray coding of a masked value never sets bits above the field MSB,
    // so the result stays inside the field.
    function automatic logic [IDX_W-1:0] code_of(input logic [IDX_W-1:0] x,
                                                 input logic [IDX_W-1:0] m);
        logic [IDX_W-1:0] v;
        v = x & m;
`ifdef ENCODE_LSPS_PACK_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // The IDLE cycle that still carries done_pack is a recovery cycle:
    // start_pack is only taken once done_pack has dropped, which gives a
    // 40-cycle period and a 4-cycle bit_valid gap for back-to-back frames.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = (start_pack && !done_pack_q) ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: state_d = (b_q == 2'd0 && i_q == 4'd9) ? S_DONE : S_SHIFT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    assign cur_bit = code_q[i_q][b_q];
    assign wr_idx  = 6'(TOTAL_BITS - 1) - nbit_q;

    always_comb begin
        code_d       = code_q;
        bits_out_d   = bits_out_q;
        nbit_d       = nbit_q;
        bit_serial_d = bit_serial_q;
        bit_valid_d  = bit_valid_q;
        done_pack_d  = done_pack_q;
        i_d          = i_q;
        b_d          = b_q;

        case (state_q)
            S_IDLE: begin
                done_pack_d = 1'b0;
                bit_valid_d = 1'b0;
            end
            S_LOAD: begin
                for (int k = 0; k < N_IDX; k++) begin
                    code_d[k] = code_of(idx_in[k], field_mask(k));
                end
                bits_out_d  = '0;
                nbit_d      = '0;
                i_d         = 4'd0;
                b_d         = 2'd3;
                bit_valid_d = 1'b0;
                done_pack_d = 1'b0;
            end
            S_SHIFT: begin
                bit_serial_d       = cur_bit;
                bit_valid_d        = 1'b1;
                bits_out_d[wr_idx] = cur_bit;
                nbit_d             = nbit_q + 6'd1;
                if (b_q != 2'd0) begin
                    b_d = b_q - 2'd1;
                end else if (i_q != 4'd9) begin
                    i_d = i_q + 4'd1;
                    b_d = msb_ptr(i_q + 4'd1);
                end
            end
            S_DONE: begin
                done_pack_d = 1'b1;
                bit_valid_d = 1'b0;
            end
            default: begin
                done_pack_d = 1'b0;
                bit_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_IDX; k++) begin
                code_q[k] <= '0;
            end
            bits_out_q   <= '0;
            nbit_q       <= '0;
            bit_serial_q <= 1'b0;
            bit_valid_q  <= 1'b0;
            done_pack_q  <= 1'b0;
            i_q          <= 4'd0;
            b_q          <= 2'd0;
        end else begin
            code_q       <= code_d;
            bits_out_q   <= bits_out_d;
            nbit_q       <= nbit_d;
            bit_serial_q <= bit_serial_d;
            bit_valid_q  <= bit_valid_d;
            done_pack_q  <= done_pack_d;
            i_q          <= i_d;
            b_q          <= b_d;
        end
    end

    assign bits_out   = bits_out_q;
    assign nbit       = nbit_q;
    assign bit_serial = bit_serial_q;
    assign bit_valid  = bit_valid_q;
    assign done_pack  = done_pack_q;

endmodule

// File: tb/tb_encode_lsps_pack.sv
// ----------------------------------------------------------------------------
// tb_encode_lsps_pack
//
// Directed bench for encode_lsps_pack. Expected frames are hand-computed from
// the field layout 4,4,4,4,4,4,4,3,3,2 (MSB first), natural or Gray coded
// depending on ENCODE_LSPS_PACK_GRAY_EN.
// ----------------------------------------------------------------------------
module tb_encode_lsps_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_pack;
    logic [3:0]  idx [10];
    logic [35:0] bits_out;
    logic        bit_serial;
    logic        bit_valid;
    logic [5:0]  nbit;
    logic        done_pack;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations gathered by run_frame
    int          valid_cnt;
    int          done_cnt;
    int          first_valid;
    int          last_valid;
    int          done_c;
    logic [35:0] ser_vec;

    always #5 clk = ~clk;

    encode_lsps_pack dut (
        .clk        (clk),
        .rst        (rst),
        .start_pack (start_pack),
        .indexes0   (idx[0]),
        .indexes1   (idx[1]),
        .indexes2   (idx[2]),
        .indexes3   (idx[3]),
        .indexes4   (idx[4]),
        .indexes5   (idx[5]),
        .indexes6   (idx[6]),
        .indexes7   (idx[7]),
        .indexes8   (idx[8]),
        .indexes9   (idx[9]),
        .bits_out   (bits_out),
        .bit_serial (bit_serial),
        .bit_valid  (bit_valid),
        .nbit       (nbit),
        .done_pack  (done_pack)
    );

    // Pulses start_pack so it is sampled at edge E0, then observes the
    // outputs for ncyc cycles. Observation c is taken just after edge Ec.
    // pulse2_at >= 0 pulses start again at that edge; chg_at >= 0 drives all
    // indexes to 4'hF after that edge.
    task automatic run_frame(input int ncyc, input int pulse2_at, input int chg_at);
        valid_cnt   = 0;
        done_cnt    = 0;
        first_valid = -1;
        last_valid  = -1;
        done_c      = -1;
        ser_vec     = '0;
        start_pack  = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start_pack = (c + 1 == pulse2_at);
            if (c == chg_at) begin
                for (int k = 0; k < 10; k++) idx[k] = 4'hF;
            end
            if (bit_valid) begin
                ser_vec = {ser_vec[34:0], bit_serial};
                valid_cnt++;
                if (first_valid < 0) first_valid = c;
                last_valid = c;
            end
            if (done_pack) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
        end
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        start_pack = 1'b0;
        for (int k = 0; k < 10; k++) idx[k] = 4'h0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bits_out !== 36'h0) begin n_bad++; $display("FAIL reset_bits_out: got %h expected %h", bits_out, 36'h0); end
        n_cmp++; if (nbit !== 6'd0) begin n_bad++; $display("FAIL reset_nbit: got %0d expected 0", nbit); end
        n_cmp++; if (bit_serial !== 1'b0) begin n_bad++; $display("FAIL reset_bit_serial: got %b expected 0", bit_serial); end
        n_cmp++; if (bit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_bit_valid: got %b expected 0", bit_valid); end
        n_cmp++; if (done_pack !== 1'b0) begin n_bad++; $display("FAIL reset_done_pack: got %b expected 0", done_pack); end
        rst = 1'b0;
    endtask

    // All fields at maximum, started on the first edge after reset release.
    task automatic test_all_ones;
        logic [35:0] exp_bits;
`ifdef ENCODE_LSPS_PACK_GRAY_EN
        exp_bits = 36'h888888892;
`else
        exp_bits = 36'hFFFFFFFFF;
`endif
        for (int k = 0; k < 10; k++) idx[k] = 4'hF;
        run_frame(45, -1, -1);
        n_cmp++; if (bits_out !== exp_bits) begin n_bad++; $display("FAIL ones_bits_out: got %h expected %h", bits_out, exp_bits); end
        n_cmp++; if (nbit !== 6'd36) begin n_bad++; $display("FAIL ones_nbit: got %0d expected 36", nbit); end
        n_cmp++; if (ser_vec !== exp_bits) begin n_bad++; $display("FAIL ones_serial: got %h expected %h", ser_vec, exp_bits); end
        n_cmp++; if (valid_cnt !== 36) begin n_bad++; $display("FAIL ones_valid_cnt: got %0d expected 36", valid_cnt); end
        n_cmp++; if (first_valid !== 2) begin n_bad++; $display("FAIL ones_first_valid: got %0d expected 2", first_valid); end
        n_cmp++; if (last_valid !== 37) begin n_bad++; $display("FAIL ones_last_valid: got %0d expected 37", last_valid); end
        n_cmp++; if (done_c !== 38) begin n_bad++; $display("FAIL ones_done_cycle: got %0d expected 38", done_c); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ones_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_single_index;
        logic [35:0] exp_bits;
`ifdef ENCODE_LSPS_PACK_GRAY_EN
        exp_bits = 36'hF00000000;
`else
        exp_bits = 36'hA00000000;
`endif
        for (int k = 0; k < 10; k++) idx[k] = 4'h0;
        idx[0] = 4'hA;
        run_frame(45, -1, -1);
        n_cmp++; if (bits_out !== exp_bits) begin n_bad++; $display("FAIL single_bits_out: got %h expected %h", bits_out, exp_bits); end
        n_cmp++; if (ser_vec !== exp_bits) begin n_bad++; $display("FAIL single_serial: got %h expected %h", ser_vec, exp_bits); end
        n_cmp++; if (nbit !== 6'd36) begin n_bad++; $display("FAIL single_nbit: got %0d expected 36", nbit); end
    endtask

    // Narrow fields must drop their upper bits.
    task automatic test_masking;
        logic [35:0] exp_bits;
`ifdef ENCODE_LSPS_PACK_GRAY_EN
        exp_bits = 36'h000000082;
`else
        exp_bits = 36'h0000000E3;
`endif
        for (int k = 0; k < 10; k++) idx[k] = 4'h0;
        idx[7] = 4'hF;
        idx[9] = 4'hF;
        run_frame(45, -1, -1);
        n_cmp++; if (bits_out !== exp_bits) begin n_bad++; $display("FAIL mask_bits_out: got %h expected %h", bits_out, exp_bits); end
        n_cmp++; if (ser_vec !== exp_bits) begin n_bad++; $display("FAIL mask_serial: got %h expected %h", ser_vec, exp_bits); end
    endtask

    // idx[k] = k, then all inputs forced to F mid-frame; frame must not change.
    task automatic test_index_stable;
        logic [35:0] exp_bits;
`ifdef ENCODE_LSPS_PACK_GRAY_EN
        exp_bits = 36'h013267581;
`else
        exp_bits = 36'h0123456E1;
`endif
        for (int k = 0; k < 10; k++) idx[k] = 4'(k);
        run_frame(45, -1, 5);
        n_cmp++; if (bits_out !== exp_bits) begin n_bad++; $display("FAIL stable_bits_out: got %h expected %h", bits_out, exp_bits); end
        n_cmp++; if (ser_vec !== exp_bits) begin n_bad++; $display("FAIL stable_serial: got %h expected %h", ser_vec, exp_bits); end
    endtask

    // Second start pulse at E10 is ignored and never queued.
    task automatic test_ignore_second;
        for (int k = 0; k < 10; k++) idx[k] = 4'h0;
        idx[0] = 4'hA;
        run_frame(90, 10, -1);
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ignore_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_c !== 38) begin n_bad++; $display("FAIL ignore_done_cycle: got %0d expected 38", done_c); end
        n_cmp++; if (valid_cnt !== 36) begin n_bad++; $display("FAIL ignore_valid_cnt: got %0d expected 36", valid_cnt); end
    endtask

    // Reset at E20 aborts the frame; a fresh frame then completes normally.
    task automatic test_reset_mid;
        int          vcnt;
        int          dcnt;
        logic [35:0] exp_bits;
        vcnt = 0;
        dcnt = 0;
        for (int k = 0; k < 10; k++) idx[k] = 4'h5;
        start_pack = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start_pack = 1'b0;
            if (c == 19) rst = 1'b1;
            if (c == 20) begin
                n_cmp++; if (bits_out !== 36'h0) begin n_bad++; $display("FAIL midrst_bits_out: got %h expected %h", bits_out, 36'h0); end
                n_cmp++; if (nbit !== 6'd0) begin n_bad++; $display("FAIL midrst_nbit: got %0d expected 0", nbit); end
                n_cmp++; if (bit_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_bit_valid: got %b expected 0", bit_valid); end
                n_cmp++; if (bit_serial !== 1'b0) begin n_bad++; $display("FAIL midrst_bit_serial: got %b expected 0", bit_serial); end
                rst = 1'b0;
            end
            if (c > 20) begin
                if (bit_valid) vcnt++;
                if (done_pack) dcnt++;
            end
        end
        n_cmp++; if (dcnt !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d expected 0", dcnt); end
        n_cmp++; if (vcnt !== 0) begin n_bad++; $display("FAIL midrst_no_valid: got %0d expected 0", vcnt); end
`ifdef ENCODE_LSPS_PACK_GRAY_EN
        exp_bits = 36'hF00000000;
`else
        exp_bits = 36'hA00000000;
`endif
        for (int k = 0; k < 10; k++) idx[k] = 4'h0;
        idx[0] = 4'hA;
        run_frame(45, -1, -1);
        n_cmp++; if (bits_out !== exp_bits) begin n_bad++; $display("FAIL midrst_restart_bits: got %h expected %h", bits_out, exp_bits); end
        n_cmp++; if (done_c !== 38) begin n_bad++; $display("FAIL midrst_restart_done: got %0d expected 38", done_c); end
    endtask

    // start_pack held for 200 sampled edges (E0..E199): frames start at
    // E0, E40, E80, E120, E160 -> 5 done pulses, 40 cycles apart.
    task automatic test_back_to_back;
        int dcnt;
        int prev_done;
        int lowrun;
        int gap;
        bit seen_high;
        dcnt      = 0;
        prev_done = -1;
        lowrun    = 0;
        gap       = -1;
        seen_high = 1'b0;
        for (int k = 0; k < 10; k++) idx[k] = 4'h3;
        start_pack = 1'b1;
        for (int c = 0; c < 260; c++) begin
            @(negedge clk);
            if (c == 199) start_pack = 1'b0;
            if (done_pack) begin
                if (prev_done >= 0) begin
                    n_cmp++;
                    if (c - prev_done !== 40) begin n_bad++; $display("FAIL b2b_period: got %0d expected 40", c - prev_done); end
                end
                prev_done = c;
                dcnt++;
            end
            if (!bit_valid) begin
                if (seen_high) lowrun++;
            end else begin
                if (seen_high && lowrun > 0 && gap < 0) gap = lowrun;
                seen_high = 1'b1;
                lowrun    = 0;
            end
        end
        n_cmp++; if (dcnt !== 5) begin n_bad++; $display("FAIL b2b_done_cnt: got %0d expected 5", dcnt); end
        n_cmp++; if (gap !== 4) begin n_bad++; $display("FAIL b2b_valid_gap: got %0d expected 4", gap); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_index();
        test_masking();
        test_index_stable();
        test_ignore_second();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
